// File: rtl/pc_fetch_controller_if.sv
// Instruction-memory fetch handshake: request/address out, grant/valid/data back.
interface pc_fetch_controller_if #(
  parameter int unsigned PC_WIDTH = 16
);
  logic                fetchReq;
  logic [PC_WIDTH-1:0] fetchAddr;
  logic                fetchGnt;
  logic                fetchValid;
  logic [PC_WIDTH-1:0] fetchData;

  modport master (
    output fetchReq,
    output fetchAddr,
    input  fetchGnt,
    input  fetchValid,
    input  fetchData
  );

  modport slave (
    input  fetchReq,
    input  fetchAddr,
    output fetchGnt,
    output fetchValid,
    output fetchData
  );
endinterface

// File: rtl/pc_fetch_controller.sv
// PC sequencing and single-outstanding instruction fetch for the 16-bit MIPS core.
// Handles branch/jump redirects, stale-response discard and decode back-pressure.
module pc_fetch_controller #(
  parameter int unsigned         PC_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned         INST_STEP = 2
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  stall,
  input  logic                  branchTaken,
  input  logic [PC_WIDTH-1:0]   branchTarget,
  input  logic                  jump,
  input  logic [PC_WIDTH-1:0]   jumpTarget,
  pc_fetch_controller_if.master fetch_if,
  output logic                  instValid,
  output logic [PC_WIDTH-1:0]   instOut,
  output logic [PC_WIDTH-1:0]   instPc,
  output logic [PC_WIDTH-1:0]   currentPc
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_HOLD
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [PC_WIDTH-1:0] r_current_pc;
  logic [PC_WIDTH-1:0] w_current_pc_nxt;
  logic [PC_WIDTH-1:0] r_req_pc;
  logic [PC_WIDTH-1:0] w_req_pc_nxt;
  logic                r_drop;
  logic                w_drop_nxt;
  logic                r_inst_valid;
  logic                w_inst_valid_nxt;
  logic [PC_WIDTH-1:0] r_inst_out;
  logic [PC_WIDTH-1:0] w_inst_out_nxt;
  logic [PC_WIDTH-1:0] r_inst_pc;
  logic [PC_WIDTH-1:0] w_inst_pc_nxt;

  logic                w_redirect;
  logic [PC_WIDTH-1:0] w_target;
  logic [PC_WIDTH-1:0] w_pc_inc;

  // Jump wins over branch; targets are forced halfword-aligned.
  assign w_redirect = jump | branchTaken;
  assign w_target   = (jump ? jumpTarget : branchTarget) & ~PC_WIDTH'(1);
  assign w_pc_inc   = r_current_pc + PC_WIDTH'(INST_STEP);

  assign fetch_if.fetchReq  = (r_state == ST_FETCH);
  assign fetch_if.fetchAddr = r_current_pc;
  assign instValid          = r_inst_valid;
  assign instOut            = r_inst_out;
  assign instPc             = r_inst_pc;
  assign currentPc          = r_current_pc;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath update; a redirect overrides stall and the increment.
  always_comb begin
    w_state_nxt      = r_state;
    w_current_pc_nxt = r_current_pc;
    w_req_pc_nxt     = r_req_pc;
    w_drop_nxt       = r_drop;
    w_inst_valid_nxt = r_inst_valid;
    w_inst_out_nxt   = r_inst_out;
    w_inst_pc_nxt    = r_inst_pc;

    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
        if (w_redirect) begin
          w_current_pc_nxt = w_target;
        end
      end

      ST_FETCH: begin
        if (fetch_if.fetchGnt) begin
          w_req_pc_nxt     = r_current_pc;
          w_current_pc_nxt = w_redirect ? w_target : w_pc_inc;
          w_drop_nxt       = w_redirect;
          w_state_nxt      = ST_WAIT;
        end else if (w_redirect) begin
          w_current_pc_nxt = w_target;
        end
      end

      ST_WAIT: begin
        if (w_redirect) begin
          w_current_pc_nxt = w_target;
        end
        if (fetch_if.fetchValid) begin
          w_drop_nxt = 1'b0;
          if (w_redirect || r_drop) begin
            w_state_nxt = ST_FETCH;
          end else begin
            w_inst_out_nxt   = fetch_if.fetchData;
            w_inst_pc_nxt    = r_req_pc;
            w_inst_valid_nxt = 1'b1;
            w_state_nxt      = ST_HOLD;
          end
        end else if (w_redirect) begin
          w_drop_nxt = 1'b1;
        end
      end

      ST_HOLD: begin
        if (w_redirect || !stall) begin
          w_inst_valid_nxt = 1'b0;
          w_state_nxt      = ST_FETCH;
        end
        if (w_redirect) begin
          w_current_pc_nxt = w_target;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_current_pc <= RESET_PC;
      r_req_pc     <= '0;
      r_drop       <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst_out   <= '0;
      r_inst_pc    <= '0;
    end else begin
      r_current_pc <= w_current_pc_nxt;
      r_req_pc     <= w_req_pc_nxt;
      r_drop       <= w_drop_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_inst_out   <= w_inst_out_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Bench for pc_fetch_controller: directed scenarios plus randomized redirects,
// stalls, memory latency and resets, checked by an architectural scoreboard.
module tb_pc_fetch_controller;

  localparam logic [15:0] RESET_PC = 16'h0000;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        rstN;
  logic        stall;
  logic        branchTaken;
  logic [15:0] branchTarget;
  logic        jump;
  logic [15:0] jumpTarget;
  logic        instValid;
  logic [15:0] instOut;
  logic [15:0] instPc;
  logic [15:0] currentPc;

  pc_fetch_controller_if #(.PC_WIDTH(16)) fi ();

  pc_fetch_controller #(
    .PC_WIDTH (16),
    .RESET_PC (RESET_PC),
    .INST_STEP(2)
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .stall       (stall),
    .branchTaken (branchTaken),
    .branchTarget(branchTarget),
    .jump        (jump),
    .jumpTarget  (jumpTarget),
    .fetch_if    (fi.master),
    .instValid   (instValid),
    .instOut     (instOut),
    .instPc      (instPc),
    .currentPc   (currentPc)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_cons  = 0;
  exp_t exp_q[$];
  logic [15:0] exp_pc;
  bit   mem_random = 1'b0;
  int   mem_delay  = 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory image: every address has a distinct, easily recomputed instruction.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1234;
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Drive decode/redirect inputs and advance the architectural model:
  // the next consumed instruction is the last redirect target, else previous+2.
  task automatic drive(input logic s, input logic br, input logic [15:0] bt,
                       input logic j, input logic [15:0] jt);
    logic [15:0] tgt;
    stall        = s;
    branchTaken  = br;
    branchTarget = bt;
    jump         = j;
    jumpTarget   = jt;
    tgt          = j ? jt : bt;
    tgt[0]       = 1'b0;
    if (!rstN) begin
      exp_pc = RESET_PC;
      exp_q.delete();
    end else if (j || br) begin
      exp_pc = tgt;
    end else if (instValid && !s) begin
      exp_q.push_back('{pc: exp_pc, data: mem_word(exp_pc)});
      exp_pc = exp_pc + 16'd2;
    end
  endtask

  task automatic tick(input logic s, input logic br, input logic [15:0] bt,
                      input logic j, input logic [15:0] jt);
    @(negedge clk);
    drive(s, br, bt, j, jt);
  endtask

  task automatic wait_fetch(input string nm, input logic [15:0] ea);
    int n;
    n = 0;
    tick(1'b0, 1'b0, '0, 1'b0, '0);
    #2;
    while (!fi.fetchReq && n < 60) begin
      tick(1'b0, 1'b0, '0, 1'b0, '0);
      #2;
      n++;
    end
    check({nm, "_req"}, 16'(fi.fetchReq), 16'h1);
    check({nm, "_addr"}, fi.fetchAddr, ea);
  endtask

  task automatic wait_inst(input string nm);
    int n;
    n = 0;
    tick(1'b1, 1'b0, '0, 1'b0, '0);
    #2;
    while (!instValid && n < 60) begin
      tick(1'b1, 1'b0, '0, 1'b0, '0);
      #2;
      n++;
    end
    check({nm, "_valid"}, 16'(instValid), 16'h1);
  endtask

  // Memory model: grants when requested, answers the latched address later.
  initial begin : memory
    bit          pend;
    int          cnt;
    logic [15:0] addr;
    pend = 1'b0;
    cnt  = 0;
    addr = '0;
    fi.fetchGnt   = 1'b0;
    fi.fetchValid = 1'b0;
    fi.fetchData  = '0;
    forever begin
      @(negedge clk);
      fi.fetchGnt   = 1'b0;
      fi.fetchValid = 1'b0;
      fi.fetchData  = 16'($urandom);
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          fi.fetchValid = 1'b1;
          fi.fetchData  = mem_word(addr);
          pend          = 1'b0;
        end
      end else if (fi.fetchReq && (!mem_random || $urandom_range(0, 2) != 0)) begin
        fi.fetchGnt = 1'b1;
        addr        = fi.fetchAddr;
        pend        = 1'b1;
        cnt         = mem_random ? int'($urandom_range(1, 4)) : mem_delay;
      end
    end
  end

  // Monitor: every instruction decode actually accepts is scored against the model.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rstN && instValid && !stall && !jump && !branchTaken) begin
        n_cons++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_inst", instPc, 16'hxxxx);
        end else begin
          e = exp_q.pop_front();
          check("sb_inst_pc", instPc, e.pc);
          check("sb_inst_data", instOut, e.data);
        end
      end
    end
  end

  initial begin : driver
    int r;
    rstN   = 1'b0;
    exp_pc = RESET_PC;
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    repeat (3) tick(1'b0, 1'b0, '0, 1'b0, '0);
    #2;
    check("rst_fetchReq", 16'(fi.fetchReq), 16'h0);
    check("rst_instValid", 16'(instValid), 16'h0);
    check("rst_currentPc", currentPc, RESET_PC);
    check("rst_instPc", instPc, 16'h0000);
    check("rst_instOut", instOut, 16'h0000);
    rstN = 1'b1;

    // First fetch, then hold the instruction under stall.
    wait_fetch("first_fetch", 16'h0000);
    tick(1'b1, 1'b0, '0, 1'b0, '0);
    #2;
    check("pc_after_grant", currentPc, 16'h0002);
    check("wait_no_req", 16'(fi.fetchReq), 16'h0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, '0, 1'b0, '0);
      #2;
      check("stall_valid", 16'(instValid), 16'h1);
      check("stall_inst", instOut, 16'h1234);
      check("stall_no_req", 16'(fi.fetchReq), 16'h0);
    end
    tick(1'b0, 1'b0, '0, 1'b0, '0);
    tick(1'b0, 1'b0, '0, 1'b0, '0);
    #2;
    check("release_req", 16'(fi.fetchReq), 16'h1);
    check("release_addr", fi.fetchAddr, 16'h0002);

    wait_fetch("seq_4", 16'h0004);
    wait_fetch("seq_6", 16'h0006);
    // Branch in WAIT with the response arriving the same cycle.
    tick(1'b0, 1'b1, 16'h0041, 1'b0, '0);
    wait_fetch("branch_fetch", 16'h0040);
    check("branch_killed", 16'(instValid), 16'h0);
    // Jump and branch together in the grant cycle: jump wins, fetch dropped.
    drive(1'b0, 1'b1, 16'h0200, 1'b1, 16'h0100);
    wait_fetch("jump_prio_fetch", 16'h0100);
    wait_inst("jump_inst");
    check("jump_inst_pc", instPc, 16'h0100);

    // Kill the held instruction with a jump to the top of memory, then wrap.
    drive(1'b1, 1'b0, '0, 1'b1, 16'hFFFE);
    wait_fetch("wrap_fetch", 16'hFFFE);
    wait_inst("wrap_inst");
    check("wrap_inst_pc", instPc, 16'hFFFE);
    check("wrap_inst_data", instOut, mem_word(16'hFFFE));
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    wait_fetch("wrap_next", 16'h0000);
    check("wrap_currentPc", currentPc, 16'h0000);

    // Reset pulse during WAIT with a late response.
    mem_delay = 3;
    wait_fetch("pre_rst_fetch", 16'h0002);
    @(negedge clk);
    rstN = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    #2;
    check("midrst_instValid", 16'(instValid), 16'h0);
    check("midrst_fetchReq", 16'(fi.fetchReq), 16'h0);
    check("midrst_currentPc", currentPc, RESET_PC);
    check("midrst_instPc", instPc, 16'h0000);
    check("midrst_instOut", instOut, 16'h0000);
    @(negedge clk);
    rstN = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    mem_delay = 1;
    wait_fetch("post_rst_fetch", RESET_PC);
    tick(1'b1, 1'b0, '0, 1'b0, '0);
    #2;
    check("late_resp_ignored", 16'(instValid), 16'h0);
    wait_inst("post_rst_inst");
    check("post_rst_inst_pc", instPc, RESET_PC);
    check("post_rst_inst_data", instOut, 16'h1234);
    drive(1'b0, 1'b0, '0, 1'b0, '0);

    // Randomized traffic.
    mem_random = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rstN = ($urandom_range(0, 299) != 0);
      r    = int'($urandom_range(0, 99));
      drive($urandom_range(0, 9) < 4, (r < 5), 16'($urandom),
            (r >= 3 && r < 8), 16'($urandom));
    end
    rstN = 1'b1;
    repeat (40) tick(1'b0, 1'b0, '0, 1'b0, '0);
    #4;
    check("sb_progress", 16'(n_cons > 150), 16'h1);
    check("sb_drained", 16'(exp_q.size()), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
